ddr2uart_reader: RTL and testbench

DDR2UART_READER -- requirements
Module: ddr2uart_reader

---
 rtl/ddr2uart_reader_pkg.sv | 27 ++
 rtl/ddr2uart_reader_uart_tx_byte.sv | 74 +++++++
 rtl/ddr2uart_reader.sv | 161 ++++++++++++++++
 tb/tb_ddr2uart_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2uart_reader_pkg.sv
// Shared definitions for the DDR-to-UART readback engine: MCB instruction
// codes, FSM state encoding and the word-to-byte helper.
package ddr2uart_reader_pkg;

  // MCB instruction codes
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Readback FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_SEND      = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Bytes per word for the default 128-bit MCB data port
  localparam int BYTES_PER_WORD = 16;

  // Bytes carried by one MCB read word of the given width
  function automatic int bytes_per_word(input int data_port_size);
    return data_port_size / 8;
  endfunction

endpackage

// File: rtl/ddr2uart_reader_uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit,
// each held for BIT_CYC clocks. ready_o is high whenever a new byte is accepted.
module uart_tx_byte #(
  parameter int BIT_CYC = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic          busy_q,  busy_d;
  logic [CW-1:0] cyc_q,   cyc_d;
  logic [3:0]    bit_q,   bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;

  // Bit timing and shifting: bit_q counts start(0), data(1..8), stop(9)
  always_comb begin
    busy_d  = busy_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, data_i};
        tx_d    = 1'b0;
        bit_d   = 4'd0;
        cyc_d   = '0;
      end else begin
        tx_d = 1'b1;
      end
    end else if (cyc_q == CW'(BIT_CYC - 1)) begin
      cyc_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  // Serializer state register; reset drops any frame in flight back to idle-high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      cyc_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign ready_o = ~busy_q;
  assign tx_o    = tx_q;

endmodule

// File: rtl/ddr2uart_reader.sv
// Reads a run of words from the MCB read port one at a time and streams
// each word out of the UART, least-significant byte first.
module ddr2uart_reader
  import ddr2uart_reader_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_PORT_SIZE = 128
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     start_addr_i,
  input  logic [15:0]               word_cnt_i,
  input  logic                      calib_done_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      p0_cmd_en_o,
  output logic [2:0]                p0_cmd_instr_o,
  output logic [5:0]                p0_cmd_bl_o,
  output logic [ADDR_WIDTH-1:0]     p0_cmd_byte_addr_o,
  input  logic                      p0_cmd_full_i,
  output logic                      p0_rd_en_o,
  input  logic [DATA_PORT_SIZE-1:0] p0_rd_data_i,
  input  logic                      p0_rd_empty_i,
  output logic                      uart_tx_o
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int BYTES   = bytes_per_word(DATA_PORT_SIZE);
  localparam int IDX_W   = $clog2(BYTES) + 1;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q,  addr_d;
  logic [15:0]               cnt_q,   cnt_d;
  logic [DATA_PORT_SIZE-1:0] data_q,  data_d;
  logic [IDX_W-1:0]          idx_q,   idx_d;
  logic                      busy_q,  busy_d;
  logic                      done_q,  done_d;
  logic                      cmd_en_s;
  logic                      rd_en_s;
  logic                      ser_start_s;
  logic                      ser_ready_s;

  // Next-state logic; MCB strobes are gated by the FIFO flags in the same cycle
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    idx_d       = idx_q;
    cmd_en_s    = 1'b0;
    rd_en_s     = 1'b0;
    ser_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && calib_done_i) begin
          if (word_cnt_i != 16'd0) begin
            addr_d  = start_addr_i & ~ADDR_WIDTH'(BYTES - 1);
            cnt_d   = word_cnt_i;
            state_d = ST_CMD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (!p0_cmd_full_i) begin
          cmd_en_s = 1'b1;
          state_d  = ST_WAIT_DATA;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WAIT_DATA: begin
        if (!p0_rd_empty_i) begin
          rd_en_s = 1'b1;
          data_d  = p0_rd_data_i;
          idx_d   = '0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_SEND: begin
        if (ser_ready_s) begin
          if (idx_q == IDX_W'(BYTES)) begin
            state_d = ST_NEXT;
          end else begin
            ser_start_s = 1'b1;
            data_d      = {8'h00, data_q[DATA_PORT_SIZE-1:8]};
            idx_d       = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        addr_d = addr_q + ADDR_WIDTH'(BYTES);
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and status registers
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= 16'd0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .BIT_CYC (BIT_CYC)
  ) u_tx (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .data_i  (data_q[7:0]),
    .start_i (ser_start_s),
    .ready_o (ser_ready_s),
    .tx_o    (uart_tx_o)
  );

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign p0_cmd_en_o        = cmd_en_s;
  assign p0_cmd_instr_o     = CMD_READ;
  assign p0_cmd_bl_o        = 6'd0;
  assign p0_cmd_byte_addr_o = addr_q;
  assign p0_rd_en_o         = rd_en_s;

endmodule

// File: tb/tb_ddr2uart_reader.sv
// Bench for ddr2uart_reader: MCB read-port model, UART receiver and a
// word-level reference model of the expected address and byte streams.
module tb_ddr2uart_reader;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 250000;
  localparam int AW       = 30;
  localparam int DPS      = 128;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int BPW      = DPS / 8;

  logic           sys_clk_i     = 1'b0;
  logic           sys_rst_i     = 1'b1;
  logic           start_i       = 1'b0;
  logic [AW-1:0]  start_addr_i  = '0;
  logic [15:0]    word_cnt_i    = 16'd0;
  logic           calib_done_i  = 1'b0;
  logic           busy_o;
  logic           done_o;
  logic           p0_cmd_en_o;
  logic [2:0]     p0_cmd_instr_o;
  logic [5:0]     p0_cmd_bl_o;
  logic [AW-1:0]  p0_cmd_byte_addr_o;
  logic           p0_cmd_full_i = 1'b0;
  logic           p0_rd_en_o;
  logic [DPS-1:0] p0_rd_data_i  = '0;
  logic           p0_rd_empty_i = 1'b1;
  logic           uart_tx_o;

  ddr2uart_reader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW), .DATA_PORT_SIZE(DPS)
  ) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .word_cnt_i(word_cnt_i), .calib_done_i(calib_done_i),
    .busy_o(busy_o), .done_o(done_o), .p0_cmd_en_o(p0_cmd_en_o),
    .p0_cmd_instr_o(p0_cmd_instr_o), .p0_cmd_bl_o(p0_cmd_bl_o),
    .p0_cmd_byte_addr_o(p0_cmd_byte_addr_o), .p0_cmd_full_i(p0_cmd_full_i),
    .p0_rd_en_o(p0_rd_en_o), .p0_rd_data_i(p0_rd_data_i),
    .p0_rd_empty_i(p0_rd_empty_i), .uart_tx_o(uart_tx_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] cmd_log[$];
  logic [7:0]    rx_q[$];
  int rd_pops = 0, rd_while_empty = 0, cmd_while_full = 0, cmd_bad_fields = 0;
  int done_pulses = 0, tx_low_cycles = 0, framing_err = 0;
  int rd_lat = 2;
  logic [7:0] seed = 8'h00;

  // Memory contents: byte i of the word at address a
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a, input int i, input logic [7:0] s);
    logic [7:0] lo;
    lo = 8'(a >> 4);
    return 8'(i) + s + lo * 8'd3;
  endfunction

  function automatic logic [DPS-1:0] mem_word(input logic [AW-1:0] a, input logic [7:0] s);
    logic [DPS-1:0] w;
    for (int i = 0; i < BPW; i++) w[8*i +: 8] = mem_byte(a, i, s);
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MCB model: log commands, present the word rd_lat cycles later, drop it on pop
  initial begin : mcb_model
    logic cmd_seen, rd_seen, pend_valid;
    logic [AW-1:0] cmd_addr, pend_addr;
    int pend_wait;
    pend_valid = 1'b0;
    pend_wait  = 0;
    pend_addr  = '0;
    forever begin
      @(negedge sys_clk_i);
      cmd_seen = p0_cmd_en_o;
      cmd_addr = p0_cmd_byte_addr_o;
      rd_seen  = p0_rd_en_o;
      if (cmd_seen && p0_cmd_full_i) cmd_while_full++;
      if (cmd_seen && (p0_cmd_instr_o !== 3'b001 || p0_cmd_bl_o !== 6'd0)) cmd_bad_fields++;
      if (rd_seen && p0_rd_empty_i) rd_while_empty++;
      @(posedge sys_clk_i);
      #1;
      if (cmd_seen) begin
        cmd_log.push_back(cmd_addr);
        pend_valid = 1'b1;
        pend_addr  = cmd_addr;
        pend_wait  = rd_lat;
      end
      if (rd_seen) begin
        rd_pops++;
        p0_rd_empty_i = 1'b1;
      end else if (pend_valid) begin
        if (pend_wait == 0) begin
          p0_rd_data_i  = mem_word(pend_addr, seed);
          p0_rd_empty_i = 1'b0;
          pend_valid    = 1'b0;
        end else begin
          pend_wait--;
        end
      end
    end
  end

  // Pulse and line-activity counters
  initial begin : pulse_mon
    forever begin
      @(negedge sys_clk_i);
      if (done_o === 1'b1) done_pulses++;
      if (uart_tx_o !== 1'b1) tx_low_cycles++;
    end
  end

  // UART receiver sampling mid-bit
  initial begin : uart_mon
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge sys_clk_i);
      if (uart_tx_o === 1'b0) begin
        repeat (BIT_CYC / 2) @(negedge sys_clk_i);
        for (int k = 0; k < 8; k++) begin
          repeat (BIT_CYC) @(negedge sys_clk_i);
          b[k] = uart_tx_o;
        end
        repeat (BIT_CYC) @(negedge sys_clk_i);
        if (uart_tx_o === 1'b1) rx_q.push_back(b);
        else framing_err++;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start(input logic [AW-1:0] a, input logic [15:0] n);
    @(posedge sys_clk_i);
    #1;
    start_addr_i = a;
    word_cnt_i   = n;
    start_i      = 1'b1;
    @(posedge sys_clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, c;
    d0 = done_pulses;
    c  = 0;
    while (done_pulses == d0 && c < budget) begin
      @(negedge sys_clk_i);
      c++;
    end
    check({tag, "_done_seen"}, 64'(done_pulses != d0), 64'd1);
  endtask

  // Run one readback and compare against the reference address/byte streams
  task automatic run_check(input string tag, input logic [AW-1:0] a, input int n);
    logic [AW-1:0] base, wa;
    logic [AW-1:0] exp_cmd[$];
    logic [7:0]    exp_rx[$];
    int c0, r0, d0;
    base = AW'((a / BPW) * BPW);
    for (int k = 0; k < n; k++) begin
      wa = AW'(base + BPW * k);
      exp_cmd.push_back(wa);
      for (int i = 0; i < BPW; i++) exp_rx.push_back(mem_byte(wa, i, seed));
    end
    c0 = cmd_log.size();
    r0 = rx_q.size();
    d0 = done_pulses;
    pulse_start(a, 16'(n));
    wait_done(tag, 2000 * n + 200);
    check({tag, "_bytes_at_done"}, 64'(rx_q.size() - r0), 64'(n * BPW));
    repeat (10) @(negedge sys_clk_i);
    check({tag, "_done_once"}, 64'(done_pulses - d0), 64'd1);
    check({tag, "_cmd_count"}, 64'(cmd_log.size() - c0), 64'(n));
    for (int k = 0; k < n && (c0 + k) < cmd_log.size(); k++)
      check({tag, "_cmd_addr"}, 64'(cmd_log[c0 + k]), 64'(exp_cmd[k]));
    check({tag, "_byte_count"}, 64'(rx_q.size() - r0), 64'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && (r0 + i) < rx_q.size(); i++)
      check({tag, "_byte"}, 64'(rx_q[r0 + i]), 64'(exp_rx[i]));
    check({tag, "_idle_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin : main
    int c, r0, c0, p0, t0, d0;
    logic [AW-1:0] a;

    // Reset state
    calib_done_i = 1'b1;
    repeat (3) @(posedge sys_clk_i);
    #1;
    check("rst_tx", 64'(uart_tx_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cmd_en", 64'(p0_cmd_en_o), 64'd0);
    check("rst_rd_en", 64'(p0_rd_en_o), 64'd0);
    check("rst_instr", 64'(p0_cmd_instr_o), 64'd1);
    check("rst_bl", 64'(p0_cmd_bl_o), 64'd0);
    check("rst_addr", 64'(p0_cmd_byte_addr_o), 64'd0);
    sys_rst_i = 1'b0;
    repeat (2) @(posedge sys_clk_i);

    // Single word at 0x100, data bytes 0x00..0x0F
    seed = 8'hD0;
    r0 = rx_q.size();
    run_check("basic", 30'h100, 1);
    for (int i = 0; i < BPW && (r0 + i) < rx_q.size(); i++)
      check("basic_literal_byte", 64'(rx_q[r0 + i]), 64'(i));

    // Address wrap across the top of the address space
    seed = 8'($urandom);
    c0 = cmd_log.size();
    run_check("wrap", 30'h3FFFFFF0, 2);
    if (cmd_log.size() >= c0 + 2) check("wrap_second_addr", 64'(cmd_log[c0 + 1]), 64'd0);

    // Unaligned start address
    seed = 8'($urandom);
    c0 = cmd_log.size();
    run_check("unaligned", 30'h105, 1);
    if (cmd_log.size() > c0) check("unaligned_addr", 64'(cmd_log[c0]), 64'h100);

    // Zero-length request
    c0 = cmd_log.size();
    p0 = rd_pops;
    t0 = tx_low_cycles;
    pulse_start(30'h200, 16'd0);
    c = 0;
    while (done_o !== 1'b1 && c < 5) begin
      @(negedge sys_clk_i);
      c++;
    end
    check("zero_done_latency_ok", 64'(c <= 2), 64'd1);
    repeat (50) @(negedge sys_clk_i);
    check("zero_no_cmd", 64'(cmd_log.size() - c0), 64'd0);
    check("zero_no_rd", 64'(rd_pops - p0), 64'd0);
    check("zero_tx_idle", 64'(tx_low_cycles - t0), 64'd0);

    // Start ignored without calibration
    calib_done_i = 1'b0;
    c0 = cmd_log.size();
    d0 = done_pulses;
    pulse_start(30'h300, 16'd1);
    repeat (20) @(negedge sys_clk_i);
    check("nocal_busy", 64'(busy_o), 64'd0);
    check("nocal_no_cmd", 64'(cmd_log.size() - c0), 64'd0);
    check("nocal_no_done", 64'(done_pulses - d0), 64'd0);
    calib_done_i = 1'b1;

    // Command FIFO full, then read FIFO empty, with stray starts while busy
    seed = 8'($urandom);
    a = 30'h4A0;
    rd_lat = 20;
    p0_cmd_full_i = 1'b1;
    c0 = cmd_log.size();
    p0 = rd_pops;
    r0 = rx_q.size();
    d0 = done_pulses;
    pulse_start(a, 16'd1);
    pulse_start(30'h7770, 16'd3);
    repeat (8) @(posedge sys_clk_i);
    #1;
    check("stall_busy", 64'(busy_o), 64'd1);
    check("stall_no_cmd_while_full", 64'(cmd_log.size() - c0), 64'd0);
    p0_cmd_full_i = 1'b0;
    c = 0;
    while (cmd_log.size() == c0 && c < 10) begin
      @(negedge sys_clk_i);
      c++;
    end
    check("stall_cmd_after_full", 64'(cmd_log.size() - c0), 64'd1);
    repeat (15) @(negedge sys_clk_i);
    check("stall_no_rd_while_empty", 64'(rd_pops - p0), 64'd0);
    pulse_start(30'h8880, 16'd2);
    wait_done("stall", 2500);
    repeat (10) @(negedge sys_clk_i);
    check("stall_one_cmd", 64'(cmd_log.size() - c0), 64'd1);
    if (cmd_log.size() > c0) check("stall_cmd_addr", 64'(cmd_log[c0]), 64'(a));
    check("stall_bytes", 64'(rx_q.size() - r0), 64'(BPW));
    for (int i = 0; i < BPW && (r0 + i) < rx_q.size(); i++)
      check("stall_byte", 64'(rx_q[r0 + i]), 64'(mem_byte(a, i, seed)));
    check("stall_done_once", 64'(done_pulses - d0), 64'd1);
    rd_lat = 2;

    // Randomized requests
    for (int t = 0; t < 3; t++) begin
      seed   = 8'($urandom);
      rd_lat = int'($urandom_range(0, 5));
      run_check("random", AW'($urandom), int'($urandom_range(1, 3)));
    end
    rd_lat = 2;

    // Reset in the third data bit of the fifth byte, then a clean restart
    seed = 8'($urandom);
    r0 = rx_q.size();
    pulse_start(30'h1230, 16'd1);
    c = 0;
    while (rx_q.size() < r0 + 4 && c < 1000) begin
      @(negedge sys_clk_i);
      c++;
    end
    check("midrst_reach_byte4", 64'(rx_q.size() - r0 >= 4), 64'd1);
    c = 0;
    while (uart_tx_o !== 1'b0 && c < 20) begin
      @(negedge sys_clk_i);
      c++;
    end
    repeat (4 + 2 * BIT_CYC + 1) @(posedge sys_clk_i);
    #1;
    sys_rst_i = 1'b1;
    @(posedge sys_clk_i);
    #1;
    check("midrst_tx", 64'(uart_tx_o), 64'd1);
    check("midrst_busy", 64'(busy_o), 64'd0);
    sys_rst_i = 1'b0;
    repeat (60) @(posedge sys_clk_i);
    seed = 8'($urandom);
    run_check("restart", 30'h5550, 1);

    check("framing_errors", 64'(framing_err), 64'd0);
    check("rd_while_empty", 64'(rd_while_empty), 64'd0);
    check("cmd_while_full", 64'(cmd_while_full), 64'd0);
    check("cmd_fields", 64'(cmd_bad_fields), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
